// File: rtl/hcu_pkg.sv
// Shared definitions for the SHA-2 hash compute unit: sequencer state encoding and word constants.
package hcu_pkg;

  localparam int unsigned SHA_WORD64_W = 64;
  localparam int unsigned SHA_WORD32_W = 32;

  // Lower half of a 64-bit word when operating on 32-bit words.
  localparam logic [SHA_WORD32_W-1:0] ZERO_FILL32 = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/madd_32_64.sv
// Mode-switched modular adder: full 64-bit add, or 32-bit add on the upper halves with zero lower half.
module madd_32_64
  import hcu_pkg::*;
(
  input  logic                    mode64,
  input  logic [SHA_WORD64_W-1:0] a,
  input  logic [SHA_WORD64_W-1:0] b,
  output logic [SHA_WORD64_W-1:0] y
);

  logic [SHA_WORD32_W-1:0] hi32;

  assign hi32 = a[SHA_WORD64_W-1:SHA_WORD32_W] + b[SHA_WORD64_W-1:SHA_WORD32_W];
  assign y    = mode64 ? (a + b) : {hi32, ZERO_FILL32};

endmodule

// File: rtl/madd_acc_seq.sv
// Multi-operand accumulation sequencer around one madd_32_64 adder.
// Optional MADD_ACC_SEQ_REG_OUT_EN adds a FLUSH state and a dedicated sum output register.
module madd_acc_seq
  import hcu_pkg::*;
#(
  parameter int unsigned MAX_OPS = 5,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_ops,
  input  logic                    mode64_in,
  output logic                    busy,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [SHA_WORD64_W-1:0] op_data,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [SHA_WORD64_W-1:0] sum,
  output logic                    sum_mode64
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OPS);

  seq_state_e              state_q, state_d;
  logic [SHA_WORD64_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        nops_q, nops_d;
  logic                    mode_q, mode_d;
  logic                    busy_q, op_ready_q, sum_valid_q;
  logic [SHA_WORD64_W-1:0] add_y;
`ifdef MADD_ACC_SEQ_REG_OUT_EN
  logic [SHA_WORD64_W-1:0] out_q, out_d;
`endif

  madd_32_64 u_madd (
    .mode64 (mode_q),
    .a      (acc_q),
    .b      (op_data),
    .y      (add_y)
  );

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      nops_q      <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      sum_valid_q <= 1'b0;
`ifdef MADD_ACC_SEQ_REG_OUT_EN
      out_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      nops_q      <= nops_d;
      mode_q      <= mode_d;
      busy_q      <= (state_d != ST_IDLE);
      op_ready_q  <= (state_d == ST_ACC);
      sum_valid_q <= (state_d == ST_DONE);
`ifdef MADD_ACC_SEQ_REG_OUT_EN
      out_q       <= out_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    nops_d  = nops_q;
    mode_d  = mode_q;
`ifdef MADD_ACC_SEQ_REG_OUT_EN
    out_d   = out_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nops_d = (n_ops > MAX_C) ? MAX_C : n_ops;
          mode_d = mode64_in;
          acc_d  = '0;
          cnt_d  = '0;
`ifdef MADD_ACC_SEQ_REG_OUT_EN
          out_d  = '0;
`endif
          state_d = (n_ops == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (op_valid && op_ready_q) begin
          acc_d = add_y;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == nops_q - CNT_W'(1)) begin
`ifdef MADD_ACC_SEQ_REG_OUT_EN
            state_d = ST_FLUSH;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_FLUSH: begin
`ifdef MADD_ACC_SEQ_REG_OUT_EN
        out_d = acc_q;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (sum_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign op_ready   = op_ready_q;
  assign sum_valid  = sum_valid_q;
  assign sum_mode64 = mode_q;
`ifdef MADD_ACC_SEQ_REG_OUT_EN
  assign sum        = out_q;
`else
  assign sum        = acc_q;
`endif

endmodule

// File: tb/tb_madd_acc_seq.sv
// Scoreboard bench for madd_acc_seq: directed jobs push expected results, a monitor pops on each result handshake.
module tb_madd_acc_seq;

  localparam int unsigned CNT_W = 3;
`ifdef MADD_ACC_SEQ_REG_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_ops;
  logic             mode64_in;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [63:0]      op_data;
  logic             sum_valid;
  logic             sum_ready;
  logic [63:0]      sum;
  logic             sum_mode64;

  int tests  = 0;
  int fails  = 0;
  int popped = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic        mode64;
  } exp_t;

  exp_t exp_q[$];

  madd_acc_seq #(.MAX_OPS(5), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_ops      (n_ops),
    .mode64_in  (mode64_in),
    .busy       (busy),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum        (sum),
    .sum_mode64 (sum_mode64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every result handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        popped++;
        chk("sb_sum", sum, e.sum);
        chk("sb_mode64", {63'd0, sum_mode64}, {63'd0, e.mode64});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n, input logic m);
    start = 1'b1; n_ops = CNT_W'(n); mode64_in = m;
    tick();
    start = 1'b0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    chk("start_op_ready", {63'd0, op_ready}, {63'd0, (n != 0)});
  endtask

  task automatic send_op(input logic [63:0] d);
    int i;
    op_valid = 1'b1; op_data = d;
    for (i = 0; i < 20 && !op_ready; i++) tick();
    if (!op_ready) chk("op_ready_timeout", 64'd0, 64'd1);
    tick();
    op_valid = 1'b0;
  endtask

  // Right after the last operand handshake: check result latency.
  task automatic check_latency();
    if (LAT == 2) begin
      chk("lat_flush_valid", {63'd0, sum_valid}, 64'd0);
      tick();
    end
    chk("lat_sum_valid", {63'd0, sum_valid}, 64'd1);
    chk("lat_op_ready", {63'd0, op_ready}, 64'd0);
  endtask

  task automatic take_result();
    int i;
    bit got = 1'b0;
    sum_ready = 1'b1;
    for (i = 0; i < 20 && !got; i++) begin
      if (sum_valid) got = 1'b1;
      tick();
    end
    sum_ready = 1'b0;
    if (!got) chk("sum_valid_timeout", 64'd0, 64'd1);
    chk("after_result_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_op_ready"}, {63'd0, op_ready}, 64'd0);
    chk({tag, "_sum_valid"}, {63'd0, sum_valid}, 64'd0);
    chk({tag, "_sum"}, sum, 64'd0);
    chk({tag, "_sum_mode64"}, {63'd0, sum_mode64}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_ops = '0; mode64_in = 1'b0;
    op_valid = 1'b0; op_data = '0; sum_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // 64-bit wrap
    start_job(2, 1'b1);
    exp_q.push_back('{sum: 64'h0000_0000_0000_0001, mode64: 1'b1});
    send_op(64'hFFFF_FFFF_FFFF_FFFF);
    send_op(64'h0000_0000_0000_0002);
    check_latency();
    take_result();

    // 32-bit mode: lower halves ignored, upper halves wrap mod 2^32
    start_job(3, 1'b0);
    exp_q.push_back('{sum: 64'h0000_0005_0000_0000, mode64: 1'b0});
    send_op(64'h8000_0000_DEAD_BEEF);
    send_op(64'h8000_0000_DEAD_BEEF);
    send_op(64'h0000_0005_1234_5678);
    check_latency();
    take_result();

    // Backpressure: gapped op_valid, spurious start while busy, stalled sum_ready
    start_job(5, 1'b1);
    exp_q.push_back('{sum: 64'd15, mode64: 1'b1});
    for (int k = 1; k <= 5; k++) begin
      send_op(64'(k));
      if (k < 5) begin
        start = 1'b1; n_ops = CNT_W'(1);
        tick();
        start = 1'b0;
      end
    end
    check_latency();
    op_valid = 1'b1; op_data = 64'h100;
    for (int k = 0; k < 5; k++) begin
      chk("stall_sum", sum, 64'd15);
      chk("stall_valid", {63'd0, sum_valid}, 64'd1);
      chk("stall_op_ready", {63'd0, op_ready}, 64'd0);
      tick();
    end
    op_valid = 1'b0;
    take_result();
    tick();
    chk("ignored_start_busy", {63'd0, busy}, 64'd0);

    // n_ops = 0: result on the next cycle
    start_job(0, 1'b1);
    exp_q.push_back('{sum: 64'd0, mode64: 1'b1});
    chk("zero_ops_valid", {63'd0, sum_valid}, 64'd1);
    chk("zero_ops_sum", sum, 64'd0);
    take_result();

    // n_ops = 7 clamps to 5
    start_job(7, 1'b1);
    exp_q.push_back('{sum: 64'd5, mode64: 1'b1});
    for (int k = 0; k < 5; k++) send_op(64'd1);
    check_latency();
    op_valid = 1'b1; op_data = 64'd1;
    tick();
    op_valid = 1'b0;
    chk("clamp_sum_hold", sum, 64'd5);
    take_result();

    // Mid-job reset discards the partial sum
    start_job(4, 1'b1);
    send_op(64'd10);
    send_op(64'd20);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("midrst");
    start_job(3, 1'b1);
    exp_q.push_back('{sum: 64'd6, mode64: 1'b1});
    send_op(64'd1);
    send_op(64'd2);
    send_op(64'd3);
    check_latency();
    take_result();

    tick();
    chk("results_popped", 64'(popped), 64'd6);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/madd_acc_seq.md
# madd_acc_seq

Multi-operand accumulation sequencer for the SHA-2 hash compute unit. It owns one madd_32_64 instance and streams N operands through it, for example T1 = h + Σ1 + Ch + K + W. It accumulates modulo 2^64 (SHA-512 mode) or 2^32 (SHA-256 mode) and returns the final sum over a valid/ready handshake. It sits between the round-function operand muxes and the working-variable update logic.

## Interface
- MAX_OPS, 5, maximum operands per job (≥1)
- CNT_W, 3, width of operand count/counter; must hold MAX_OPS
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- n_ops  in  CNT_W  operand count for the job, sampled with start
- mode64_in  in  1  1 = 64-bit words, 0 = 32-bit words; sampled with start
- busy  out  1  high whenever state ≠ IDLE
- op_valid  in  1  operand available
- op_ready  out  1  sequencer accepts an operand
- op_data  in  64  operand; in 32-bit mode only [63:32] is used
- sum_valid  out  1  result available
- sum_ready  in  1  consumer accepts result
- sum  out  64  result; in 32-bit mode it is {sum32, 32'h0}
- sum_mode64  out  1  mode of the job that produced sum

## Operation
- States: IDLE, ACC, DONE. With MADD_ACC_SEQ_REG_OUT_EN there is also FLUSH between ACC and DONE.
- IDLE:
  - op_ready=0, sum_valid=0.
  - On start: latch n_ops (clamped to MAX_OPS if larger) and mode64_in, clear acc to 0 and cnt to 0.
  - If n_ops=0, go to DONE with sum 0. Otherwise go to ACC.
- ACC:
  - op_ready=1.
  - On handshake (op_valid & op_ready): acc <= madd_32_64(mode, acc, op_data) and cnt++.
  - On the handshake where cnt = n_ops−1, go to DONE (or FLUSH).
- DONE:
  - sum_valid=1; sum and sum_mode64 are held stable until sum_ready.
  - On sum_valid & sum_ready, go to IDLE.
- Arithmetic:
  - 64-bit mode: wraps modulo 2^64.
  - 32-bit mode: the upper halves add modulo 2^32. op_data[31:0] is ignored and sum[31:0] is always 0.
- start is ignored outside IDLE; it is never queued.
- op_valid outside ACC is ignored; no operand is consumed.
- Reset:
  - Takes priority over all inputs and is honoured in any state.
  - The next cycle is IDLE with acc=0, cnt=0, and every output 0 (busy, op_ready, sum_valid, sum, sum_mode64).
  - A partial sum is discarded.

## Timing
- start accepted at cycle t → busy=1 and op_ready=1 at t+1.
- Last operand handshake at cycle k → sum_valid=1 at k+1.
- n_ops=0 with start at t → sum_valid at t+1.
- Result handshake at cycle d → busy=0 at d+1; a new start is accepted at d+1.
- Minimum job length for N operands: 1 (start) + N (operands) + 1 (result) cycles.
- Throughput: one operand per cycle with op_valid held high.
- The adder is combinational; acc is the only register in the accumulate path.

## Configuration
- MADD_ACC_SEQ_REG_OUT_EN defined:
  - Adds a FLUSH state and a dedicated output register loaded from acc in FLUSH.
  - sum_valid asserts at k+2, and sum is driven from that register.
- MADD_ACC_SEQ_REG_OUT_EN undefined:
  - No FLUSH state; sum is driven directly from acc.
  - Latency is k+1.
- Handshake rules are identical in both builds.

## Structure
- Shared package hcu_pkg holds:
  - the state encoding typedef (IDLE, ACC, FLUSH, DONE);
  - the constant SHA_WORD64_W = 64;
  - the 32-bit mode zero-fill constant.
- One sub-module: madd_32_64 (the existing mode-switched adder), instantiated once with a = acc, b = op_data, mode64 = latched mode.
- Counter and FSM are inline; no further hierarchy.

## Test plan
- Reset: assert rst for 2 cycles mid-stream → all outputs 0, busy=0, op_ready=0.
- 64-bit wrap: n_ops=2, mode64=1, ops 0xFFFFFFFF_FFFFFFFF and 0x2 → sum=0x00000000_00000001, sum_mode64=1, sum_valid 1 cycle after the 2nd op (2 cycles with the macro).
- 32-bit mode: n_ops=3, ops 0x80000000_DEADBEEF, 0x80000000_DEADBEEF, 0x00000005_12345678 → sum=0x00000005_00000000.
- Backpressure:
  - n_ops=5, op_valid toggled 1-0-1-0…, and start pulsed while busy → the start pulse is ignored and exactly 5 ops are consumed.
  - sum_ready held 0 for 5 cycles → sum stable and op_ready=0 throughout.
- Boundaries:
  - n_ops=0 → sum_valid next cycle with sum=0.
  - n_ops=7 with MAX_OPS=5 → clamped to 5; op_ready drops after the 5th op.
- Mid-job reset: rst after 2 of 4 ops → IDLE next cycle; a following 64-bit job with ops 1,2,3 yields sum=6.
